// File: rtl/window_load_sequencer.sv
// Row-major frame-memory load sequencer for one SAD search window; one word per req/ack, mem_req one cycle after start.
// Stalls on mem_ack low with address held; define WINDOW_SEQ_PERF_EN to add the stall_cnt_o performance counter.
module window_load_sequencer #(
    parameter int FRAME_COLS = 64,
    parameter int MAX_ROWS   = 16,
    parameter int ADDR_W     = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [31:0]       window_columns_i,
    input  logic [31:0]       window_rows_i,
    input  logic              mem_ack_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [1:0]        size_code_o,
    output logic [4:0]        row_idx_o,
    output logic [4:0]        col_idx_o,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              cfg_err_o
`ifdef WINDOW_SEQ_PERF_EN
    ,
    output logic [15:0]       stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [4:0]        row_q, row_d;
    logic [4:0]        col_q, col_d;
    logic [4:0]        cols_q, cols_d;
    logic [4:0]        rows_q, rows_d;
    logic [1:0]        size_q, size_d;
    logic              cfg_err_q, cfg_err_d;

    logic              cols_legal;
    logic              rows_legal;
    logic              start_ok;
    logic [1:0]        size_dec;
    logic              col_end;
    logic              is_last;

    assign cols_legal = (window_columns_i == 32'd4) || (window_columns_i == 32'd8) ||
                        (window_columns_i == 32'd16);
    assign rows_legal = (window_rows_i != 32'd0) && (window_rows_i <= 32'(MAX_ROWS));
    assign start_ok   = (state_q == S_IDLE) && start_i && cols_legal && rows_legal;

    always_comb begin
        size_dec = 2'd2;
        if (window_columns_i == 32'd4) begin
            size_dec = 2'd0;
        end else if (window_columns_i == 32'd8) begin
            size_dec = 2'd1;
        end
    end

    assign col_end = (col_q == cols_q - 5'd1);
    assign is_last = col_end && (row_q == rows_q - 5'd1);

    // Row start address is tracked separately so a row wrap is a single add of the stride.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        row_base_d = row_base_q;
        row_d      = row_q;
        col_d      = col_q;
        cols_d     = cols_q;
        rows_d     = rows_q;
        size_d     = size_q;
        cfg_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (cols_legal && rows_legal) begin
                        state_d    = S_ISSUE;
                        addr_d     = base_addr_i;
                        row_base_d = base_addr_i;
                        row_d      = 5'd0;
                        col_d      = 5'd0;
                        cols_d     = window_columns_i[4:0];
                        rows_d     = window_rows_i[4:0];
                        size_d     = size_dec;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_ack_i) begin
                    if (is_last) begin
                        state_d = S_DONE;
                    end else if (col_end) begin
                        col_d      = 5'd0;
                        row_d      = row_q + 5'd1;
                        row_base_d = row_base_q + ADDR_W'(FRAME_COLS);
                        addr_d     = row_base_q + ADDR_W'(FRAME_COLS);
                    end else begin
                        col_d  = col_q + 5'd1;
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            row_base_q <= '0;
            row_q      <= 5'd0;
            col_q      <= 5'd0;
            cols_q     <= 5'd0;
            rows_q     <= 5'd0;
            size_q     <= 2'd0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            row_base_q <= row_base_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cols_q     <= cols_d;
            rows_q     <= rows_d;
            size_q     <= size_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

`ifdef WINDOW_SEQ_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_ok) begin
            stall_d = 16'd0;
        end else if ((state_q == S_ISSUE) && !mem_ack_i && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

    assign mem_req_o   = (state_q == S_ISSUE);
    assign busy_o      = (state_q == S_ISSUE);
    assign done_o      = (state_q == S_DONE);
    assign last_o      = (state_q == S_ISSUE) && is_last;
    assign mem_addr_o  = addr_q;
    assign size_code_o = size_q;
    assign row_idx_o   = row_q;
    assign col_idx_o   = col_q;
    assign cfg_err_o   = cfg_err_q;

endmodule
